axis_ascon_tag_gate: RTL and testbench

//   Store-and-forward release gate downstream of the decrypting axis_ascon_aead128 (m_* data and m_tag_* streams).

---
 rtl/axis_ascon_tag_gate.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axis_ascon_tag_gate.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ascon_tag_gate.sv
`default_nettype none
// ============================================================================
// Module      : axis_ascon_tag_gate
// Description : Store-and-forward release gate for decrypted AXI-Stream frames.
//               Each frame is buffered until its authentication tag result
//               arrives. A zero tag commits the frame for release. A nonzero
//               tag, or a frame too large for the buffer, rolls the frame back
//               so that no byte of it ever reaches the m_* side. Every frame
//               produces exactly one status word.
//
// Parameters  : AW                 log2 of buffer depth in beats
//
// Ports       : clk                single clock, all logic on rising edge
//               resetn             synchronous reset, active low
//               i_s_tvalid/o_s_tready        decrypted-data input handshake
//               i_s_tlast/i_s_tdata/i_s_tkeep input beat payload
//               i_s_tag_tvalid/o_s_tag_tready tag-result handshake
//               i_s_tag_tdata      0 = authentic, nonzero = failure
//               o_m_tvalid/i_m_tready        released-data handshake
//               o_m_tlast/o_m_tdata/o_m_tkeep released beat payload
//               o_m_status_tvalid/i_m_status_tready per-frame status handshake
//               o_m_status_tdata   [0] auth_fail, [1] overflow
//
// Revision    : 1.0  initial release
// ============================================================================
module axis_ascon_tag_gate #(
    parameter int AW = 6
) (
    input  logic         clk,
    input  logic         resetn,
    // decrypted data in
    input  logic         i_s_tvalid,
    output logic         o_s_tready,
    input  logic         i_s_tlast,
    input  logic [127:0] i_s_tdata,
    input  logic [15:0]  i_s_tkeep,
    // tag result in
    input  logic         i_s_tag_tvalid,
    output logic         o_s_tag_tready,
    input  logic [127:0] i_s_tag_tdata,
    // released data out
    output logic         o_m_tvalid,
    input  logic         i_m_tready,
    output logic         o_m_tlast,
    output logic [127:0] o_m_tdata,
    output logic [15:0]  o_m_tkeep,
    // per-frame status out
    output logic         o_m_status_tvalid,
    input  logic         i_m_status_tready,
    output logic [1:0]   o_m_status_tdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_BW       = 1 + 16 + 128;      // {tlast, tkeep, tdata}
    localparam int          c_DEPTH_N  = 2 ** AW;
    localparam logic [AW:0] c_DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_PTR_ONE  = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0]  c_ST_RECV     = 2'd0;
    localparam logic [1:0]  c_ST_DISCARD  = 2'd1;
    localparam logic [1:0]  c_ST_WAIT_TAG = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [AW:0]     r_wr;          // next write slot
    logic [AW:0]     r_commit;      // end of the last authenticated frame
    logic [AW:0]     r_rd;          // next slot to fetch from the buffer
    logic            r_ovf;         // current frame overflowed the buffer
    logic            r_status_vld;
    logic [1:0]      r_status;

    logic [c_BW-1:0] r_mem [c_DEPTH_N];

    // Read pipeline: RAM output register, then output register + skid slot.
    logic [c_BW-1:0] r_ram_q;
    logic            r_ram_vld;
    logic [c_BW-1:0] r_out;
    logic            r_out_vld;
    logic [c_BW-1:0] r_skid;
    logic            r_skid_vld;

    // ------------------------------------------------------------------------
    // Write-side combinational control
    // ------------------------------------------------------------------------
    logic [AW:0]     w_fill;
    logic [AW:0]     w_uncommitted;
    logic            w_overflow;
    logic            w_s_acc;
    logic            w_wr_en;
    logic            w_tag_acc;
    logic            w_tag_fail;

    assign w_fill        = r_wr - r_rd;
    assign w_uncommitted = r_wr - r_commit;

    // The frame alone occupies the whole buffer and still has no tlast: it
    // can never be committed, so it is thrown away and the rest is drained.
    assign w_overflow    = (r_state == c_ST_RECV) && (w_uncommitted == c_DEPTH);

    // s_tready depends on registered state only; the m_* ready inputs never
    // reach it combinationally.
    always_comb begin
        o_s_tready = 1'b0;
        if (resetn) begin
            case (r_state)
                c_ST_RECV:    o_s_tready = (w_fill < c_DEPTH) && !w_overflow;
                c_ST_DISCARD: o_s_tready = 1'b1;
                default:      o_s_tready = 1'b0;
            endcase
        end
    end

    // The status register is one deep, so a new tag is only taken once the
    // previous status word has been handed off.
    assign o_s_tag_tready = resetn && (r_state == c_ST_WAIT_TAG) && !r_status_vld;

    assign w_s_acc    = i_s_tvalid && o_s_tready;
    assign w_wr_en    = w_s_acc && (r_state == c_ST_RECV);
    assign w_tag_acc  = i_s_tag_tvalid && o_s_tag_tready;
    assign w_tag_fail = |i_s_tag_tdata;

    // ------------------------------------------------------------------------
    // Frame FSM and pointer management
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= c_ST_RECV;
            r_wr         <= '0;
            r_commit     <= '0;
            r_ovf        <= 1'b0;
            r_status_vld <= 1'b0;
            r_status     <= 2'b00;
        end else begin
            case (r_state)
                c_ST_RECV: begin
                    if (w_overflow) begin
                        r_ovf   <= 1'b1;
                        r_wr    <= r_commit;
                        r_state <= c_ST_DISCARD;
                    end else if (w_s_acc) begin
                        r_wr <= r_wr + c_PTR_ONE;
                        if (i_s_tlast) begin
                            r_state <= c_ST_WAIT_TAG;
                        end
                    end
                end

                c_ST_DISCARD: begin
                    if (w_s_acc && i_s_tlast) begin
                        r_state <= c_ST_WAIT_TAG;
                    end
                end

                c_ST_WAIT_TAG: begin
                    if (w_tag_acc) begin
                        if (!w_tag_fail && !r_ovf) begin
                            r_commit <= r_wr;
                        end else begin
                            // Rollback only touches beats after commit, so
                            // frames already released or queued are safe.
                            r_wr <= r_commit;
                        end
                        r_ovf   <= 1'b0;
                        r_state <= c_ST_RECV;
                    end
                end

                default: r_state <= c_ST_RECV;
            endcase

            // Status load and hand-off never collide: a tag is only accepted
            // while the status register is empty.
            if (w_tag_acc) begin
                r_status_vld <= 1'b1;
                r_status     <= {r_ovf, w_tag_fail};
            end else if (i_m_status_tready) begin
                r_status_vld <= 1'b0;
            end
        end
    end

    assign o_m_status_tvalid = r_status_vld;
    assign o_m_status_tdata  = r_status;

    // ------------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------------
    logic       w_pop;
    logic [1:0] w_occ;
    logic       w_issue;

    assign w_pop = r_out_vld && i_m_tready;

    // Beats held or in flight after this cycle's pop. The output register and
    // skid slot together hold two beats, so a fetch is issued only while that
    // leaves room for its data to land one cycle later. Counting the pop lets
    // the pipeline sustain one beat per clock.
    assign w_occ = {1'b0, r_out_vld} + {1'b0, r_skid_vld}
                 + {1'b0, r_ram_vld} - {1'b0, w_pop};

    // Uses the registered commit pointer: a commit landing this cycle becomes
    // readable on the next one.
    assign w_issue = (r_rd != r_commit) && (w_occ < 2'd2);

    // Buffer RAM: one write port, one synchronous read port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[AW-1:0]] <= {i_s_tlast, i_s_tkeep, i_s_tdata};
        end
        if (w_issue) begin
            r_ram_q <= r_mem[r_rd[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd       <= '0;
            r_ram_vld  <= 1'b0;
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
        end else begin
            r_ram_vld <= w_issue;
            if (w_issue) begin
                r_rd <= r_rd + c_PTR_ONE;
            end

            if (!r_out_vld || w_pop) begin
                // Output register is free: the skid slot (older) goes first.
                if (r_skid_vld) begin
                    r_out      <= r_skid;
                    r_out_vld  <= 1'b1;
                    r_skid_vld <= r_ram_vld;
                    if (r_ram_vld) begin
                        r_skid <= r_ram_q;
                    end
                end else if (r_ram_vld) begin
                    r_out     <= r_ram_q;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else if (r_ram_vld) begin
                // Output stalled: park the arriving beat in the skid slot.
                r_skid     <= r_ram_q;
                r_skid_vld <= 1'b1;
            end
        end
    end

    assign o_m_tvalid = r_out_vld;
    assign {o_m_tlast, o_m_tkeep, o_m_tdata} = r_out;

endmodule
`default_nettype wire

// File: tb/tb_axis_ascon_tag_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_ascon_tag_gate
// Description : Directed and randomised self-checking bench for the tag gate,
//               built with a 4-beat buffer so overflow cases stay short.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axis_ascon_tag_gate;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int TMO   = 3000;

    logic         clk = 1'b0;
    logic         resetn;
    logic         i_s_tvalid, o_s_tready, i_s_tlast;
    logic [127:0] i_s_tdata;
    logic [15:0]  i_s_tkeep;
    logic         i_s_tag_tvalid, o_s_tag_tready;
    logic [127:0] i_s_tag_tdata;
    logic         o_m_tvalid, i_m_tready, o_m_tlast;
    logic [127:0] o_m_tdata;
    logic [15:0]  o_m_tkeep;
    logic         o_m_status_tvalid, i_m_status_tready;
    logic [1:0]   o_m_status_tdata;

    always #5 clk = ~clk;

    axis_ascon_tag_gate #(.AW(AW)) u_dut (
        .clk               (clk),
        .resetn            (resetn),
        .i_s_tvalid        (i_s_tvalid),
        .o_s_tready        (o_s_tready),
        .i_s_tlast         (i_s_tlast),
        .i_s_tdata         (i_s_tdata),
        .i_s_tkeep         (i_s_tkeep),
        .i_s_tag_tvalid    (i_s_tag_tvalid),
        .o_s_tag_tready    (o_s_tag_tready),
        .i_s_tag_tdata     (i_s_tag_tdata),
        .o_m_tvalid        (o_m_tvalid),
        .i_m_tready        (i_m_tready),
        .o_m_tlast         (o_m_tlast),
        .o_m_tdata         (o_m_tdata),
        .o_m_tkeep         (o_m_tkeep),
        .o_m_status_tvalid (o_m_status_tvalid),
        .i_m_status_tready (i_m_status_tready),
        .o_m_status_tdata  (o_m_status_tdata)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    int           m_rdy_pct  = 100;
    int           st_rdy_pct = 100;
    int           gap_pct    = 0;
    bit           mon_en     = 1'b0;
    bit           run_done   = 1'b0;
    int           beats_in   = 0;
    int           beats_out  = 0;
    int           st_seen    = 0;
    int           stall_log [16];
    logic [144:0] exp_q [$];
    logic [1:0]   st_q [$];
    logic [144:0] cur_frame [$];

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    function automatic logic [144:0] mk_beat(input int id, input int idx, input int len,
                                             input logic [15:0] keep_last);
        logic [31:0]  a;
        logic [31:0]  b;
        logic [127:0] d;
        a = id;
        b = idx;
        d = {a, b, ~a, 32'hC0DE_0000 ^ b};
        return {(idx == len - 1), (idx == len - 1) ? keep_last : 16'hFFFF, d};
    endfunction

    // All stimulus tasks start and end at posedge + 1.
    task automatic idle_gap();
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_beat(input logic [144:0] b, output int waits);
        idle_gap();
        i_s_tvalid = 1'b1;
        {i_s_tlast, i_s_tkeep, i_s_tdata} = b;
        waits = 0;
        @(negedge clk);
        while (!o_s_tready) begin
            waits++;
            if (waits > TMO) begin
                check_eq("s_tready_timeout", 160'(o_s_tready), 1);
                finish_run();
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_s_tvalid = 1'b0;
        beats_in++;
    endtask

    task automatic send_frame(input int id, input int len, input int n_send,
                              input logic [15:0] keep_last);
        logic [144:0] b;
        int           w;
        cur_frame.delete();
        for (int i = 0; i < n_send; i++) begin
            b = mk_beat(id, i, len, keep_last);
            cur_frame.push_back(b);
            send_beat(b, w);
            if (i < 16) stall_log[i] = w;
        end
    endtask

    task automatic send_tag(input logic [127:0] tag, input int len);
        int waits;
        idle_gap();
        i_s_tag_tvalid = 1'b1;
        i_s_tag_tdata  = tag;
        if (tag == 128'd0 && len <= DEPTH) begin
            foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
        end
        st_q.push_back({(len > DEPTH), (tag != 128'd0)});
        waits = 0;
        @(negedge clk);
        while (!o_s_tag_tready) begin
            waits++;
            if (waits > TMO) begin
                check_eq("tag_tready_timeout", 160'(o_s_tag_tready), 1);
                finish_run();
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_s_tag_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || st_q.size() != 0) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, exp_q.size() + st_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Ready drivers for the two output streams.
    initial begin
        i_m_tready        = 1'b0;
        i_m_status_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            i_m_tready        = ($urandom_range(99) < m_rdy_pct);
            i_m_status_tready = ($urandom_range(99) < st_rdy_pct);
        end
    end

    // Output monitors: scoreboard compare plus hold-while-stalled checks.
    initial begin
        bit           m_prev_stall;
        bit           s_prev_stall;
        logic [144:0] m_prev;
        logic [144:0] m_now;
        logic [1:0]   s_prev;
        m_prev_stall = 1'b0;
        s_prev_stall = 1'b0;
        m_prev = '0;
        s_prev = '0;
        forever begin
            @(negedge clk);
            m_now = {o_m_tlast, o_m_tkeep, o_m_tdata};
            if (!mon_en) begin
                m_prev_stall = 1'b0;
                s_prev_stall = 1'b0;
            end else begin
                if (m_prev_stall) check_eq("m_stable", {o_m_tvalid, m_now}, {1'b1, m_prev});
                if (o_m_tvalid && i_m_tready) begin
                    check_eq("beat_pending", 160'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check_eq("beat_data", m_now, exp_q.pop_front());
                    beats_out++;
                end
                m_prev_stall = o_m_tvalid && !i_m_tready;
                m_prev       = m_now;

                if (s_prev_stall) check_eq("status_stable", {o_m_status_tvalid, o_m_status_tdata}, {1'b1, s_prev});
                if (o_m_status_tvalid && i_m_status_tready) begin
                    check_eq("status_pending", 160'(st_q.size() > 0), 1);
                    if (st_q.size() > 0) check_eq("status_data", o_m_status_tdata, st_q.pop_front());
                    st_seen++;
                end
                s_prev_stall = o_m_status_tvalid && !i_m_status_tready;
                s_prev       = o_m_status_tdata;
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        check_eq("watchdog", 160'(run_done), 1);
        finish_run();
    end

    initial begin
        int           b0;
        int           o0;
        int           s0;
        int           len;
        logic [127:0] tag;

        resetn         = 1'b0;
        i_s_tvalid     = 1'b0;
        i_s_tlast      = 1'b0;
        i_s_tdata      = '0;
        i_s_tkeep      = '0;
        i_s_tag_tvalid = 1'b0;
        i_s_tag_tdata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_tready", 160'(o_s_tready), 0);
        check_eq("rst_tag_tready", 160'(o_s_tag_tready), 0);
        check_eq("rst_m_tvalid", 160'(o_m_tvalid), 0);
        check_eq("rst_status_tvalid", 160'(o_m_status_tvalid), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_release_s_tready", 160'(o_s_tready), 1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // 3-beat authentic frame, first beat two clocks after the tag
        o0 = beats_out;
        send_frame(1, 3, 3, 16'hF000);
        send_tag(128'd0, 3);
        @(negedge clk);
        @(negedge clk);
        check_eq("t1_lat_early", 160'(o_m_tvalid), 0);
        @(negedge clk);
        check_eq("t1_lat_2clk", 160'(o_m_tvalid), 1);
        wait_drain("t1_drain");
        check_eq("t1_beats_out", beats_out - o0, 3);

        // Failed tag suppresses the frame; next good frame is intact
        o0 = beats_out;
        send_frame(2, 3, 3, 16'hF000);
        send_tag(128'h1, 3);
        repeat (4) @(negedge clk);
        check_eq("t2_no_release", 160'(o_m_tvalid), 0);
        @(posedge clk); #1;
        send_frame(3, 3, 3, 16'h00FF);
        send_tag(128'd0, 3);
        wait_drain("t2_drain");
        check_eq("t2_beats_out", beats_out - o0, 3);

        // Oversize 6-beat frame: discarded after 4 beats, status overflow
        o0 = beats_out;
        send_frame(4, 6, 6, 16'h000F);
        check_eq("t3_b3_nostall", stall_log[3], 0);
        check_eq("t3_b4_one_stall", stall_log[4], 1);
        check_eq("t3_b5_discard_ready", stall_log[5], 0);
        send_tag(128'd0, 6);
        wait_drain("t3_drain");
        check_eq("t3_beats_out", beats_out - o0, 0);

        // Buffer full of a committed frame: plain stall, then both drain
        o0 = beats_out;
        m_rdy_pct = 0;
        send_frame(5, 4, 4, 16'h0F0F);
        send_tag(128'd0, 4);
        b0 = beats_in;
        fork
            send_frame(6, 4, 4, 16'hFF00);
            begin
                repeat (12) @(negedge clk);
                check_eq("t4_stall_s_tready", 160'(o_s_tready), 0);
                check_eq("t4_accepted", beats_in - b0, 2);
                check_eq("t4_held_m_tvalid", 160'(o_m_tvalid), 1);
                m_rdy_pct = 100;
            end
        join
        send_tag(128'd0, 4);
        wait_drain("t4_drain");
        check_eq("t4_beats_out", beats_out - o0, 8);

        // Random traffic on every port
        s0 = st_seen;
        m_rdy_pct  = 60;
        st_rdy_pct = 60;
        gap_pct    = 30;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 5);
            tag = 128'd0;
            if ($urandom_range(99) >= 55) tag = 128'd1 << $urandom_range(0, 127);
            send_frame(100 + f, len, len, 16'($urandom));
            send_tag(tag, len);
        end
        wait_drain("t5_drain");
        check_eq("t5_status_count", st_seen - s0, 1000);

        // Reset mid-drain and mid-frame
        m_rdy_pct  = 0;
        st_rdy_pct = 0;
        gap_pct    = 0;
        send_frame(7, 3, 3, 16'hFFFF);
        send_tag(128'd0, 3);
        send_frame(8, 3, 2, 16'hFFFF);
        check_eq("t6_pre_m_tvalid", 160'(o_m_tvalid), 1);
        check_eq("t6_pre_status_tvalid", 160'(o_m_status_tvalid), 1);
        mon_en = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_m_tvalid", 160'(o_m_tvalid), 0);
        check_eq("t6_m_payload", {o_m_tlast, o_m_tkeep, o_m_tdata}, 0);
        check_eq("t6_status", {o_m_status_tvalid, o_m_status_tdata}, 0);
        check_eq("t6_tag_tready", 160'(o_s_tag_tready), 0);
        check_eq("t6_s_tready", 160'(o_s_tready), 0);
        resetn = 1'b1;
        exp_q.delete();
        st_q.delete();
        m_rdy_pct  = 100;
        st_rdy_pct = 100;
        @(posedge clk); #1;
        mon_en = 1'b1;
        o0 = beats_out;
        send_frame(9, 3, 3, 16'hF000);
        send_tag(128'd0, 3);
        wait_drain("t6_drain");
        check_eq("t6_beats_out", beats_out - o0, 3);

        run_done = 1'b1;
        finish_run();
    end

endmodule
`default_nettype wire
